// File: rtl/lc3_ctrl_pkg.sv
// Shared types and encodings for the LC-3 control sequencer: state names,
// the packed datapath control word, opcodes and mux/ALU select values.
package lc3_ctrl_pkg;

   typedef enum logic [4:0] {
      S_HALTED, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
      S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKEN, S_JMP,
      S_JSR1, S_JSR2, S_LDR1, S_LDR2, S_LDR3,
      S_STR1, S_STR2, S_STR3, S_PAUSE1, S_PAUSE2
   } state_e;

   typedef struct packed {
      logic       LD_MAR;
      logic       LD_MDR;
      logic       LD_IR;
      logic       LD_PC;
      logic       LD_REG;
      logic       LD_BEN;
      logic       LD_CC;
      logic       GatePC;
      logic       GateMDR;
      logic       GateALU;
      logic       GateMARMUX;
      logic       DRMUX;
      logic       SR1MUX;
      logic       SR2MUX;
      logic       ADDR1MUX;
      logic       OE;
      logic [1:0] PCMUX;
      logic [1:0] ALUK;
      logic [1:0] ADDR2MUX;
   } ctrl_t;

   localparam logic [3:0] OP_BR    = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_JSR   = 4'b0100;
   localparam logic [3:0] OP_AND   = 4'b0101;
   localparam logic [3:0] OP_LDR   = 4'b0110;
   localparam logic [3:0] OP_STR   = 4'b0111;
   localparam logic [3:0] OP_NOT   = 4'b1001;
   localparam logic [3:0] OP_JMP   = 4'b1100;
   localparam logic [3:0] OP_PAUSE = 4'b1101;

   localparam logic [1:0] ALUK_ADD   = 2'b00;
   localparam logic [1:0] ALUK_AND   = 2'b01;
   localparam logic [1:0] ALUK_NOT   = 2'b10;
   localparam logic [1:0] ALUK_PASSA = 2'b11;

   localparam logic [1:0] PCMUX_INC  = 2'b00;
   localparam logic [1:0] PCMUX_ADDR = 2'b01;
   localparam logic [1:0] PCMUX_BUS  = 2'b10;

   localparam logic       ADDR1_PC  = 1'b0;
   localparam logic       ADDR1_SR1 = 1'b1;

   localparam logic [1:0] ADDR2_ZERO  = 2'b00;
   localparam logic [1:0] ADDR2_OFF6  = 2'b01;
   localparam logic [1:0] ADDR2_OFF9  = 2'b10;
   localparam logic [1:0] ADDR2_OFF11 = 2'b11;

   localparam logic OE_MEM = 1'b0;
   localparam logic OE_BUS = 1'b1;

   localparam logic SR1_IR86  = 1'b0;
   localparam logic SR1_IR119 = 1'b1;

   localparam logic DR_IR119 = 1'b0;
   localparam logic DR_R7    = 1'b1;

   // States that hold for MEM_WAIT cycles while memory completes.
   function automatic logic is_mem_state(input state_e s);
      return (s == S_FETCH2) || (s == S_LDR2) || (s == S_STR3);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Down-counter that stretches memory states: load on entry, count while
// in the state, done when the count reaches zero.
module mem_wait_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             count,
   input  logic [WIDTH-1:0] load_val,
   output logic             done
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (count && (cnt_q != '0))
         cnt_d = cnt_q - WIDTH'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/lc3_sequencer.sv
// LC-3 control sequencer: Moore FSM producing datapath control words for
// fetch/decode/execute, with memory states stretched by mem_wait_timer.
module lc3_sequencer
   import lc3_ctrl_pkg::*;
#(
   parameter int MEM_WAIT = 2   // legal range 1..15
) (
   input  logic        Clk,
   input  logic        Reset_ah,
   input  logic        Run,
   input  logic        Continue,
   input  logic [15:0] IR,
   input  logic        BEN,
   output ctrl_t       ctrl,
   output logic        Mem_WE,
   output logic        LD_LED
);

   state_e state_q, state_d;
   logic   wait_done;
   logic   wait_load;
   logic   unused_ir;

   assign unused_ir = ^{IR[10:6], IR[4:0]};

   // Reload on every entry so back-to-back instructions each get a full wait.
   assign wait_load = (state_d != state_q) && is_mem_state(state_d);

   mem_wait_timer #(.WIDTH(4)) u_wait (
      .clk      (Clk),
      .rst      (Reset_ah),
      .load     (wait_load),
      .count    (is_mem_state(state_q)),
      .load_val (4'(MEM_WAIT - 1)),
      .done     (wait_done)
   );

   always_ff @(posedge Clk or posedge Reset_ah) begin
      if (Reset_ah) state_q <= S_HALTED;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_HALTED:   if (Run) state_d = S_FETCH1;
         S_FETCH1:   state_d = S_FETCH2;
         S_FETCH2:   if (wait_done) state_d = S_FETCH3;
         S_FETCH3:   state_d = S_DECODE;
         S_DECODE: begin
            case (IR[15:12])
               OP_ADD:   state_d = S_ADD;
               OP_AND:   state_d = S_AND;
               OP_NOT:   state_d = S_NOT;
               OP_BR:    state_d = S_BR;
               OP_JMP:   state_d = S_JMP;
               OP_JSR:   state_d = S_JSR1;
               OP_LDR:   state_d = S_LDR1;
               OP_STR:   state_d = S_STR1;
               OP_PAUSE: state_d = S_PAUSE1;
               default:  state_d = S_FETCH1;
            endcase
         end
         S_ADD, S_AND, S_NOT: state_d = S_FETCH1;
         S_BR:       state_d = BEN ? S_BR_TAKEN : S_FETCH1;
         S_BR_TAKEN: state_d = S_FETCH1;
         S_JMP:      state_d = S_FETCH1;
         S_JSR1:     state_d = S_JSR2;
         S_JSR2:     state_d = S_FETCH1;
         S_LDR1:     state_d = S_LDR2;
         S_LDR2:     if (wait_done) state_d = S_LDR3;
         S_LDR3:     state_d = S_FETCH1;
         S_STR1:     state_d = S_STR2;
         S_STR2:     state_d = S_STR3;
         S_STR3:     if (wait_done) state_d = S_FETCH1;
         S_PAUSE1:   if (Continue) state_d = S_PAUSE2;
         S_PAUSE2:   if (!Continue) state_d = S_FETCH1;
         default:    state_d = S_HALTED;
      endcase
   end

   // Register-source selects only read IR fields; they are not decoded state.
   always_comb begin
      ctrl   = '0;
      Mem_WE = 1'b0;
      LD_LED = 1'b0;
      case (state_q)
         S_FETCH1: begin
            ctrl.GatePC = 1'b1;
            ctrl.LD_MAR = 1'b1;
            ctrl.LD_PC  = 1'b1;
            ctrl.PCMUX  = PCMUX_INC;
         end
         S_FETCH2, S_LDR2: begin
            ctrl.LD_MDR = 1'b1;
            ctrl.OE     = OE_MEM;
         end
         S_FETCH3: begin
            ctrl.GateMDR = 1'b1;
            ctrl.LD_IR   = 1'b1;
         end
         S_DECODE: ctrl.LD_BEN = 1'b1;
         S_ADD, S_AND, S_NOT: begin
            ctrl.GateALU = 1'b1;
            ctrl.LD_REG  = 1'b1;
            ctrl.LD_CC   = 1'b1;
            ctrl.SR1MUX  = SR1_IR86;
            ctrl.DRMUX   = DR_IR119;
            ctrl.SR2MUX  = IR[5];
            ctrl.ALUK    = (state_q == S_ADD) ? ALUK_ADD :
                           (state_q == S_AND) ? ALUK_AND : ALUK_NOT;
         end
         S_BR_TAKEN: begin
            ctrl.LD_PC    = 1'b1;
            ctrl.PCMUX    = PCMUX_ADDR;
            ctrl.ADDR1MUX = ADDR1_PC;
            ctrl.ADDR2MUX = ADDR2_OFF9;
         end
         S_JMP: begin
            ctrl.LD_PC    = 1'b1;
            ctrl.PCMUX    = PCMUX_ADDR;
            ctrl.ADDR1MUX = ADDR1_SR1;
            ctrl.ADDR2MUX = ADDR2_ZERO;
            ctrl.SR1MUX   = SR1_IR86;
         end
         S_JSR1: begin
            ctrl.GatePC = 1'b1;
            ctrl.DRMUX  = DR_R7;
            ctrl.LD_REG = 1'b1;
         end
         S_JSR2: begin
            ctrl.LD_PC = 1'b1;
            ctrl.PCMUX = PCMUX_ADDR;
            if (IR[11]) begin
               ctrl.ADDR1MUX = ADDR1_PC;
               ctrl.ADDR2MUX = ADDR2_OFF11;
            end else begin
               ctrl.ADDR1MUX = ADDR1_SR1;
               ctrl.ADDR2MUX = ADDR2_ZERO;
               ctrl.SR1MUX   = SR1_IR86;
            end
         end
         S_LDR1, S_STR1: begin
            ctrl.GateMARMUX = 1'b1;
            ctrl.LD_MAR     = 1'b1;
            ctrl.ADDR1MUX   = ADDR1_SR1;
            ctrl.ADDR2MUX   = ADDR2_OFF6;
            ctrl.SR1MUX     = SR1_IR86;
         end
         S_LDR3: begin
            ctrl.GateMDR = 1'b1;
            ctrl.LD_REG  = 1'b1;
            ctrl.LD_CC   = 1'b1;
            ctrl.DRMUX   = DR_IR119;
         end
         S_STR2: begin
            ctrl.GateALU = 1'b1;
            ctrl.ALUK    = ALUK_PASSA;
            ctrl.SR1MUX  = SR1_IR119;
            ctrl.OE      = OE_BUS;
            ctrl.LD_MDR  = 1'b1;
         end
         S_STR3:   Mem_WE = 1'b1;
         S_PAUSE1: LD_LED = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lc3_sequencer.sv
// Directed bench for lc3_sequencer: three instances (MEM_WAIT 1/2/3) share
// inputs; an instruction table drives the MEM_WAIT=2 instance.
module tb_lc3_sequencer;
   import lc3_ctrl_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset_ah, Run, Continue, BEN;
   logic [15:0] IR;
   ctrl_t       c1, c2, c3;
   logic        we1, we2, we3, led1, led2, led3;
   int          errs = 0;
   int          checks = 0;

   localparam logic [21:0] K_F1   = 22'h244000;
   localparam logic [21:0] K_F2   = 22'h100000;
   localparam logic [21:0] K_F3   = 22'h082000;
   localparam logic [21:0] K_DEC  = 22'h010000;
   localparam logic [21:0] K_STR2 = 22'h10124C;

   always #5 Clk = ~Clk;

   lc3_sequencer #(.MEM_WAIT(1)) dut1 (.Clk(Clk), .Reset_ah(Reset_ah), .Run(Run),
      .Continue(Continue), .IR(IR), .BEN(BEN), .ctrl(c1), .Mem_WE(we1), .LD_LED(led1));
   lc3_sequencer #(.MEM_WAIT(2)) dut2 (.Clk(Clk), .Reset_ah(Reset_ah), .Run(Run),
      .Continue(Continue), .IR(IR), .BEN(BEN), .ctrl(c2), .Mem_WE(we2), .LD_LED(led2));
   lc3_sequencer #(.MEM_WAIT(3)) dut3 (.Clk(Clk), .Reset_ah(Reset_ah), .Run(Run),
      .Continue(Continue), .IR(IR), .BEN(BEN), .ctrl(c3), .Mem_WE(we3), .LD_LED(led3));

   typedef struct {
      string       nm;
      logic [15:0] ir;
      logic        ben;
      logic [21:0] e1;   // control word one cycle after DECODE
      logic [21:0] e2;   // control word two cycles after DECODE
      int          k;    // cycles from DECODE until FETCH1
      int          we;   // Mem_WE cycles in that span
   } vec_t;

   localparam int NV = 11;
   vec_t tv [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Reset_ah = 1'b1;
      Run      = 1'b0;
      Continue = 1'b0;
      step();
      step();
      Reset_ah = 1'b0;
   endtask

   task automatic run_pulse();
      Run = 1'b1;
      step();
      Run = 1'b0;
   endtask

   initial begin
      tv[0]  = '{"add_reg", 16'h1042, 1'b0, 22'h029000, K_F1,       2, 0};
      tv[1]  = '{"add_imm", 16'h1061, 1'b0, 22'h029100, K_F1,       2, 0};
      tv[2]  = '{"and",     16'h5042, 1'b0, 22'h029004, K_F1,       2, 0};
      tv[3]  = '{"not",     16'h903F, 1'b0, 22'h029108, K_F1,       2, 0};
      tv[4]  = '{"br_take", 16'h0E05, 1'b1, 22'h000000, 22'h040012, 3, 0};
      tv[5]  = '{"br_not",  16'h0E05, 1'b0, 22'h000000, K_F1,       2, 0};
      tv[6]  = '{"jmp",     16'hC1C0, 1'b0, 22'h040090, K_F1,       2, 0};
      tv[7]  = '{"jsr",     16'h4800, 1'b0, 22'h024400, 22'h040013, 3, 0};
      tv[8]  = '{"jsrr",    16'h4080, 1'b0, 22'h024400, 22'h040090, 3, 0};
      tv[9]  = '{"ldr",     16'h6283, 1'b0, 22'h200881, 22'h100000, 5, 0};
      tv[10] = '{"str",     16'h7283, 1'b0, 22'h200881, K_STR2,     5, 2};

      IR = 16'h1042;
      BEN = 1'b0;
      do_reset();
      chk("reset_ctrl", 32'(c2), 32'h0);
      chk("reset_we_led", {30'b0, we2, led2}, 32'h0);
      step(); step(); step();
      chk("halted_no_run", 32'(c2), 32'h0);

      // Fetch timing on the MEM_WAIT=2 instance
      run_pulse();
      chk("fetch1", 32'(c2), 32'(K_F1));
      step(); chk("fetch2_a", 32'(c2), 32'(K_F2));
      step(); chk("fetch2_b", 32'(c2), 32'(K_F2));
      step(); chk("fetch3", 32'(c2), 32'(K_F3));
      step(); chk("decode", 32'(c2), 32'(K_DEC));

      for (int i = 0; i < NV; i++) begin
         int n, k, we;
         logic [21:0] s1, s2;
         n = 0;
         while (c2 !== K_F1 && n < 40) begin step(); n++; end
         chk({tv[i].nm, "_sync"}, 32'(n < 40), 32'h1);
         IR  = tv[i].ir;
         BEN = tv[i].ben;
         n = 0;
         while (c2 !== K_DEC && n < 40) begin step(); n++; end
         chk({tv[i].nm, "_decode"}, 32'(n < 40), 32'h1);
         k = 0; we = 0; s1 = '0; s2 = '0;
         for (int s = 1; s <= 40; s++) begin
            step();
            if (s == 1) s1 = c2;
            if (s == 2) s2 = c2;
            if (we2) we++;
            if (k == 0 && c2 === K_F1) k = s;
            if (k != 0 && s >= 2) break;
         end
         chk({tv[i].nm, "_exec1"}, 32'(s1), 32'(tv[i].e1));
         chk({tv[i].nm, "_exec2"}, 32'(s2), 32'(tv[i].e2));
         chk({tv[i].nm, "_cycles"}, 32'(k), 32'(tv[i].k));
         chk({tv[i].nm, "_memwe"}, 32'(we), 32'(tv[i].we));
      end

      // MEM_WAIT 1/2/3 side by side running STR
      begin
         int mdr1, mdr2, mdr3, w1, w2, w3;
         logic ir1, ir2, ir3, saw_str2;
         IR = 16'h7283;
         do_reset();
         run_pulse();
         mdr1 = 0; mdr2 = 0; mdr3 = 0; w1 = 0; w2 = 0; w3 = 0;
         ir1 = 0; ir2 = 0; ir3 = 0; saw_str2 = 0;
         for (int s = 0; s < 16; s++) begin
            if (s > 0) step();
            if (c1.LD_IR) ir1 = 1; else if (!ir1 && c1.LD_MDR) mdr1++;
            if (c2.LD_IR) ir2 = 1; else if (!ir2 && c2.LD_MDR) mdr2++;
            if (c3.LD_IR) ir3 = 1; else if (!ir3 && c3.LD_MDR) mdr3++;
            if (c3 === K_STR2) saw_str2 = 1;
            w1 += int'(we1); w2 += int'(we2); w3 += int'(we3);
         end
         chk("mw1_fetch_mdr", 32'(mdr1), 32'd1);
         chk("mw2_fetch_mdr", 32'(mdr2), 32'd2);
         chk("mw3_fetch_mdr", 32'(mdr3), 32'd3);
         chk("mw3_str2", 32'(saw_str2), 32'h1);
         chk("mw1_memwe", 32'(w1), 32'd2);
         chk("mw2_memwe", 32'(w2), 32'd2);
         chk("mw3_memwe", 32'(w3), 32'd3);
      end

      // Pause / Continue handshake
      begin
         int n, lit;
         IR = 16'hD0FF;
         do_reset();
         run_pulse();
         n = 0;
         while (!led2 && n < 20) begin step(); n++; end
         chk("pause_reach", 32'(n < 20), 32'h1);
         lit = 0;
         for (int s = 0; s < 10; s++) begin
            if (led2) lit++;
            step();
         end
         chk("pause_hold", 32'(lit), 32'd10);
         chk("pause_still", {31'b0, led2}, 32'h1);
         Continue = 1'b1;
         step();
         chk("pause2", {9'b0, led2, 32'(c2)}, 32'h0);
         step(); step();
         chk("pause2_hold", {9'b0, led2, 32'(c2)}, 32'h0);
         Continue = 1'b0;
         step();
         chk("pause_resume", 32'(c2), 32'(K_F1));
      end

      // Asynchronous reset in the middle of STR3
      begin
         int n;
         IR = 16'h7283;
         do_reset();
         run_pulse();
         n = 0;
         while (!we2 && n < 20) begin step(); n++; end
         chk("str3_reach", 32'(n < 20), 32'h1);
         #2 Reset_ah = 1'b1;
         #1;
         chk("async_we", {31'b0, we2}, 32'h0);
         chk("async_ctrl", 32'(c2), 32'h0);
         Run = 1'b1;
         step(); step();
         chk("rst_run_ignored", {9'b0, we2, 32'(c2)}, 32'h0);
         Reset_ah = 1'b0;
         Run = 1'b0;
         step(); step(); step();
         chk("post_rst_halted", 32'(c2), 32'h0);
         run_pulse();
         chk("post_rst_fetch", 32'(c2), 32'(K_F1));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
